// File: rtl/mux_pkg.sv
// Shared constants and helpers for the pipelined N:1 mux.
package mux_pkg;

    localparam int DATA_W = 32;

    // Select width for n inputs. Never below one bit, so a 2:1 mux still has a port.
    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nto1_comb.sv
// Pure combinational N:1 select. An out-of-range select produces zero data and flags
// sel_err_o, so the output is never X.
module mux_nto1_comb
    import mux_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int NUM_IN = 4,
    localparam int SEL_W = sel_width(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data_i,
    input  logic [SEL_W-1:0]        in_sel_i,
    output logic [WIDTH-1:0]        data_o,
    output logic                    sel_err_o
);

    always_comb begin
        data_o    = '0;
        sel_err_o = (32'(in_sel_i) >= 32'(NUM_IN));
        for (int k = 0; k < NUM_IN; k++) begin
            if (32'(in_sel_i) == 32'(k)) begin
                data_o = in_data_i[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/mux_nto1_pipe.sv
// N:1 mux with a registered valid/ready output stage backed by a one-entry skid register.
// in_ready comes from registered skid state only, so no ready path runs combinationally upstream.
module mux_nto1_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int NUM_IN = 4,
    localparam int SEL_W = sel_width(NUM_IN)
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_sel_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_err;
    logic             accept;
    logic             drain;

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic             main_err_q,   main_err_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             skid_err_q,   skid_err_d;

    mux_nto1_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_sel (
        .in_data_i (in_data),
        .in_sel_i  (in_sel),
        .data_o    (sel_data),
        .sel_err_o (sel_err)
    );

    // Valid/ready: a beat moves on a rising edge where valid and ready are both high;
    // once valid is raised, it and the payload hold until that edge.
    assign in_ready = ~skid_valid_q & ~Reset;
    assign accept   = in_valid & in_ready;
    assign drain    = main_valid_q & out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_err_d   = main_err_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_err_d   = skid_err_q;

        if (drain) begin
            main_valid_d = skid_valid_q;
            if (skid_valid_q) begin
                main_data_d  = skid_data_q;
                main_err_d   = skid_err_q;
                skid_valid_d = 1'b0;
            end
        end

        // accept implies the skid is empty, so it never collides with the skid->main move.
        if (accept) begin
            if (!main_valid_q || drain) begin
                main_valid_d = 1'b1;
                main_data_d  = sel_data;
                main_err_d   = sel_err;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = sel_data;
                skid_err_d   = sel_err;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_err_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_err_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_err_q   <= main_err_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_err_q   <= skid_err_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_data    = main_data_q;
    assign out_sel_err = main_err_q;

endmodule
